booth_radix4_seq_mult: RTL
==========================

# booth_radix4_seq_mult

Iterative radix-4 Booth multiplier that scans the multiplier three bits at a time (y[i+1], y[i], y[i-1]), decodes each triplet into the neg/pos/neg2/pos2 select set, and accumulates one partial product per clock. It is the sequential driver stage for the Booth select decoder. It serves as the low-area alternative to the pipelined Booth–Wallace multiplier, with a valid/ready handshake on both sides and signed/unsigned operation selectable per operation.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 4.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's complement, 0 = unsigned; sampled with operands.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  full-width product.
- busy  output  1  high in BUSY.

## Operation
- States:
  - IDLE: in_ready=1. Goes to BUSY on in_valid&in_ready.
  - BUSY: processes one digit per cycle for N = WIDTH/2+1 cycles, then goes to DONE.
  - DONE: out_valid=1. Goes to IDLE on out_ready.
- On accept, the block latches:
  - X = x extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Multiplier shift register M = {ext2(y), 1'b0}, WIDTH+3 bits, with the same extension rule.
  - Accumulator cleared; digit counter cleared.
- Each BUSY cycle:
  - Triplet t = M[2:0].
  - Decode rule (identical to the select decoder):
    - 000 and 111 → +0.
    - 001 and 010 → +X (pos).
    - 011 → +2X (pos2).
    - 100 → −2X (neg2).
    - 101 and 110 → −X (neg).
  - Partial product is formed at WIDTH+3 bits. Negation is done by inversion plus +1 carry-in, within the same cycle.
  - acc += pp·4^i, computed exactly.
  - M shifts right by 2 with sign/zero fill; the counter increments.
- Implementation choice: shift-accumulate (acc shifted right 2/cycle) or fixed-position add. In either case the final acc must equal the exact product.
- Signed mode:
  - The extra final digit is {s,s,s} and contributes 0.
  - Result = x·y in two's complement, 2*WIDTH bits.
- Unsigned mode:
  - The final digit absorbs the carry-out of the top bits.
  - Result = x·y unsigned, 2*WIDTH bits.
- product is registered. It loads at the BUSY→DONE transition and holds until the next load or reset. out_valid=1 in DONE only.
- Inputs are ignored outside IDLE; in_valid during BUSY/DONE has no effect.
- No same-cycle accept on DONE→IDLE. in_ready rises the cycle after the output handshake.
- Reset values: state IDLE, in_ready=1 (after the reset cycle), out_valid=0, busy=0, product=0, acc=0, counter=0.
- Reset asserted mid-BUSY or in DONE aborts the operation. The result is discarded and never presented.

## Timing
- Accept edge E0 (in_valid&in_ready=1).
- Digits are processed on edges E1…EN. out_valid is high from the cycle after EN.
- Latency: N cycles from accept edge to out_valid. For WIDTH=32 that is 17; for WIDTH=8 it is 5.
- Minimum occupancy per operation: N+2 cycles (accept, N digits, output handshake cycle).
- busy is high for exactly N cycles per operation.
- Critical path: 3-bit decode → 5-way select → (WIDTH+3)-bit negate/add into the accumulator, within one cycle.

## Test plan
- Signed small operands, WIDTH=32: x=3, y=−5 (0xFFFFFFFB), is_signed=1 → product 0xFFFFFFFFFFFFFFF1; out_valid exactly 17 cycles after accept edge.
- Unsigned max operands: x=y=0xFFFFFFFF, is_signed=0 → product 0xFFFFFFFE00000001. The same operands with is_signed=1 → product 0x0000000000000001.
- Signed corner: x=y=0x80000000, is_signed=1 → product 0x4000000000000000. Also x=0x80000000, y=0x7FFFFFFF → product 0xC000000080000000.
- Backpressure and stray inputs:
  - Hold out_ready=0 for 10 cycles in DONE → product stable, in_ready=0.
  - in_valid pulsed with new operands during BUSY/DONE → ignored.
  - After the handshake, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst at BUSY cycle 8 → next cycle state IDLE, out_valid=0, product=0. A following op (7×9 unsigned) → 63 with normal latency.
- WIDTH=8: exhaustive x,y ∈ 0..255 × both modes against a reference multiply. Each op completes in 5 cycles with no mismatches.

Source files
------------

// File: rtl/booth_radix4_seq_mult.sv
// Purpose: iterative radix-4 Booth multiplier, one partial product per clock, signed/unsigned per operation.
// Latency: WIDTH/2+1 cycles from accept edge to out_valid; one operation in flight at a time.
// Backpressure: product holds in DONE until out_ready; inputs are ignored unless in_ready (IDLE).
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; x, y, is_signed sampled on accept
//   out_valid/out_ready   result handshake; product is the registered 2*WIDTH-bit result
//   busy                  high while digits are being accumulated
module booth_radix4_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int N  = WIDTH / 2 + 1;     // digits per operation
   localparam int CW = $clog2(N + 1);
   localparam int XW = WIDTH + 2;         // extended multiplicand
   localparam int MW = WIDTH + 3;         // multiplier shift register incl. implicit y[-1]
   localparam int HW = WIDTH + 3;         // running high part of the accumulator
   localparam int LW = WIDTH + 2;         // product bits retired 2 per cycle

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [XW-1:0]        x_q;
   logic [MW-1:0]        m_q, m_d;
   logic [HW-1:0]        hi_q, hi_d;
   logic [LW-1:0]        lo_q, lo_d;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 in_ready_q, out_valid_q, busy_q;

   logic [XW-1:0]        x_ext;
   logic [MW-1:0]        m_init;
   logic [2:0]           trip;
   logic                 sel_x, sel_2x, neg;
   logic [HW-1:0]        mag, addend, sum;
   logic                 last;
   logic                 xs, ys;

   always_comb begin
      // Operand extension: two extra top bits so the unsigned final digit
      // sees zeros above y[WIDTH-1] and absorbs the carry-out.
      xs     = is_signed & x[WIDTH-1];
      ys     = is_signed & y[WIDTH-1];
      x_ext  = {xs, xs, x};
      m_init = {ys, ys, y, 1'b0};

      // Booth triplet decode
      trip   = m_q[2:0];
      sel_x  = 1'b0;
      sel_2x = 1'b0;
      neg    = 1'b0;
      case (trip)
         3'b001, 3'b010: sel_x = 1'b1;
         3'b011:         sel_2x = 1'b1;
         3'b100: begin
            sel_2x = 1'b1;
            neg    = 1'b1;
         end
         3'b101, 3'b110: begin
            sel_x = 1'b1;
            neg   = 1'b1;
         end
         default: ;
      endcase

      mag = '0;
      if (sel_2x)
         mag = {x_q, 1'b0};
      else if (sel_x)
         mag = {x_q[XW-1], x_q};

      // Negation as inversion with the +1 folded into the same adder.
      addend = neg ? ~mag : mag;
      sum    = hi_q + addend + {{(HW-1){1'b0}}, neg};

      // Shift-accumulate: the high part shifts right arithmetically and the
      // two bits falling out are final product bits. The running sum stays
      // within +/-2^(WIDTH+2), so HW bits never overflow.
      hi_d = {sum[HW-1], sum[HW-1], sum[HW-1:2]};
      lo_d = {sum[1:0], lo_q[LW-1:2]};
      m_d  = {m_q[MW-1], m_q[MW-1], m_q[MW-1:2]};
      last = (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         product_q   <= '0;
         x_q         <= '0;
         m_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q        <= x_ext;
                  m_q        <= m_init;
                  hi_q       <= '0;
                  lo_q       <= '0;
                  cnt_q      <= '0;
                  state_q    <= S_BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_BUSY: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               m_q   <= m_d;
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  // After 2N = WIDTH+2 retired bits, the low 2*WIDTH bits of
                  // {hi, lo} are the exact product.
                  product_q   <= {hi_d[WIDTH-3:0], lo_d};
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule
